// File: rtl/axi_mem_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and the axi_mem write responder.
interface axi_mem_writer_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 128,
    parameter int ID_WD   = 4
);
    logic                 awvalid;
    logic                 awready;
    logic [ID_WD-1:0]     awid;
    logic [ADDR_WD-1:0]   awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 wvalid;
    logic                 wready;
    logic [DATA_WD-1:0]   wdata;
    logic [DATA_WD/8-1:0] wstrb;
    logic                 wlast;
    logic                 bvalid;
    logic                 bready;
    logic [ID_WD-1:0]     bid;
    logic [1:0]           bresp;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axi_mem_writer.sv
// AXI4 write responder: one outstanding burst, each data beat becomes a registered strobed
// write to the 2048-entry backing store.
//   state  | meaning
//   IDLE   | awready high, waiting for a write address
//   DATA   | wready high, accepting beats until awlen+1 have arrived
//   RESP   | bvalid high, holding bid/bresp until bready
module axi_mem_writer #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 128,
    parameter int ID_WD   = 4,
    parameter int IDX_WD  = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axi_mem_writer_if.slave      axi,
    output logic                 mem_wr_en,
    output logic [IDX_WD-1:0]    mem_wr_idx,
    output logic [DATA_WD-1:0]   mem_wr_data,
    output logic [DATA_WD/8-1:0] mem_wr_strb
);
    localparam int BPB = DATA_WD / 8;
    localparam int LSB = $clog2(BPB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        state;
    logic [ID_WD-1:0]  id_q;
    logic [7:0]        len_q;
    logic [1:0]        burst_q;
    logic [IDX_WD-1:0] idx_q;
    logic [7:0]        cnt_q;
    logic              aw_err_q;
    logic              err_q;

    logic              aw_bad;
    logic              wrap_len_ok;
    logic              last_beat;
    logic              wlast_bad;
    logic [IDX_WD-1:0] wrap_mask;
    logic [IDX_WD-1:0] idx_inc;
    logic [IDX_WD-1:0] idx_nxt;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^axi.awaddr[ADDR_WD-1:LSB+IDX_WD];

    assign wrap_len_ok = (axi.awlen == 8'd1) || (axi.awlen == 8'd3) ||
                         (axi.awlen == 8'd7) || (axi.awlen == 8'd15);
    assign aw_bad = (axi.awsize != 3'(LSB)) || (axi.awburst == 2'b11) ||
                    ((axi.awburst == 2'b10) && !wrap_len_ok) ||
                    (axi.awaddr[LSB-1:0] != '0);

    assign last_beat = (cnt_q == len_q);
    assign wlast_bad = (axi.wlast != last_beat);

    // A legal WRAP length is 2^n-1, so len itself is the mask of the bits that roll over.
    assign wrap_mask = IDX_WD'(len_q);
    assign idx_inc   = idx_q + IDX_WD'(1);

    always_comb begin
        idx_nxt = idx_inc;
        case (burst_q)
            2'b00:   idx_nxt = idx_q;
            2'b10:   idx_nxt = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
            default: idx_nxt = idx_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            id_q        <= '0;
            len_q       <= '0;
            burst_q     <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            aw_err_q    <= 1'b0;
            err_q       <= 1'b0;
            axi.awready <= 1'b1;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bid     <= '0;
            axi.bresp   <= 2'b00;
            mem_wr_en   <= 1'b0;
            mem_wr_idx  <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (axi.awvalid && axi.awready) begin
                        id_q        <= axi.awid;
                        len_q       <= axi.awlen;
                        burst_q     <= axi.awburst;
                        idx_q       <= axi.awaddr[LSB+IDX_WD-1:LSB];
                        cnt_q       <= '0;
                        aw_err_q    <= aw_bad;
                        err_q       <= aw_bad;
                        axi.awready <= 1'b0;
                        axi.wready  <= 1'b1;
                        state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (axi.wvalid && axi.wready) begin
                        // A wlast mismatch only spoils the response; the data is still written.
                        mem_wr_en   <= !aw_err_q;
                        mem_wr_idx  <= idx_q;
                        mem_wr_data <= axi.wdata;
                        mem_wr_strb <= axi.wstrb;
                        idx_q       <= idx_nxt;
                        cnt_q       <= cnt_q + 8'd1;
                        if (wlast_bad) begin
                            err_q <= 1'b1;
                        end
                        if (last_beat) begin
                            axi.wready <= 1'b0;
                            axi.bvalid <= 1'b1;
                            axi.bid    <= id_q;
                            axi.bresp  <= (err_q || wlast_bad) ? 2'b10 : 2'b00;
                            state      <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (axi.bvalid && axi.bready) begin
                        axi.bvalid  <= 1'b0;
                        axi.awready <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_writer.sv
// Self-checking bench for axi_mem_writer: directed vector table, reset corner cases and
// randomized bursts against an arithmetic model of the addressing and error rules.
module tb_axi_mem_writer;
    localparam int ADDR_WD = 32;
    localparam int DATA_WD = 128;
    localparam int ID_WD   = 4;
    localparam int IDX_WD  = 11;
    localparam int BPB     = 16;
    localparam int TMO     = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_mem_writer_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD)) axi ();

    logic                 mem_wr_en;
    logic [IDX_WD-1:0]    mem_wr_idx;
    logic [DATA_WD-1:0]   mem_wr_data;
    logic [DATA_WD/8-1:0] mem_wr_strb;

    axi_mem_writer #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD), .ID_WD(ID_WD), .IDX_WD(IDX_WD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axi         (axi.slave),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_idx  (mem_wr_idx),
        .mem_wr_data (mem_wr_data),
        .mem_wr_strb (mem_wr_strb)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every cycle with mem_wr_en high is one observed write.
    longint          cyc = 0;
    longint          last_wr_cyc = -1;
    longint          b_rise_cyc = -1;
    logic            bv_prev = 1'b0;
    logic [10:0]     obs_idx[$];
    logic [127:0]    obs_data[$];
    logic [15:0]     obs_strb[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) begin
                obs_idx.push_back(mem_wr_idx);
                obs_data.push_back(mem_wr_data);
                obs_strb.push_back(mem_wr_strb);
                last_wr_cyc = cyc;
            end
            if (axi.bvalid && !bv_prev) b_rise_cyc = cyc;
        end
        bv_prev = axi.bvalid;
    end

    function automatic bit model_aw_err(input logic [1:0] b, input logic [31:0] a,
                                        input logic [7:0] l, input logic [2:0] s);
        bit wrap_ok;
        wrap_ok = (l == 1) || (l == 3) || (l == 7) || (l == 15);
        return (s != 3'd4) || (b == 2'b11) || (b == 2'b10 && !wrap_ok) || (a % BPB != 0);
    endfunction

    function automatic logic [10:0] model_idx(input logic [1:0] b, input logic [31:0] a,
                                              input int len, input int k);
        int start, n, base;
        start = (a / BPB) % 2048;
        n = len + 1;
        if (b == 2'b00) return 11'(start);
        if (b == 2'b10) begin
            base = start - (start % n);
            return 11'(base + ((start % n) + k) % n);
        end
        return 11'((start + k) % 2048);
    endfunction

    logic [127:0] beat_data[32];
    logic [15:0]  beat_strb[32];

    task automatic wait_for(input string name, input int which);
        int to = 0;
        while (to < TMO && !((which == 0 && axi.awready) || (which == 1 && axi.wready) ||
                             (which == 2 && axi.bvalid))) begin
            @(negedge clk);
            to++;
        end
        if (to >= TMO) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic run_burst(input logic [1:0] b, input logic [31:0] a, input logic [7:0] l,
                             input logic [2:0] s, input logic [3:0] id, input int last_at,
                             input int bwait, input bit gaps);
        bit awe, pe;
        int n;
        logic [1:0] exp_resp;
        awe = model_aw_err(b, a, l, s);
        pe = (last_at != int'(l));
        exp_resp = (awe || pe) ? 2'b10 : 2'b00;
        n = awe ? 0 : int'(l) + 1;
        obs_idx.delete();
        obs_data.delete();
        obs_strb.delete();
        b_rise_cyc = -1;
        last_wr_cyc = -1;

        @(negedge clk);
        axi.awvalid = 1'b1;
        axi.awid = id;
        axi.awaddr = a;
        axi.awlen = l;
        axi.awsize = s;
        axi.awburst = b;
        wait_for("aw", 0);
        @(negedge clk);
        axi.awvalid = 1'b0;
        for (int k = 0; k <= int'(l); k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                axi.wvalid = 1'b0;
                @(negedge clk);
            end
            axi.wvalid = 1'b1;
            axi.wdata = beat_data[k];
            axi.wstrb = beat_strb[k];
            axi.wlast = (k == last_at);
            wait_for("w", 1);
            @(negedge clk);
        end
        axi.wvalid = 1'b0;
        axi.wlast = 1'b0;
        wait_for("b", 2);
        check("bid", axi.bid, id);
        check("bresp", axi.bresp, exp_resp);
        for (int i = 0; i < bwait; i++) begin
            @(negedge clk);
            check("b_hold_valid", axi.bvalid, 1);
            check("b_hold_id", axi.bid, id);
            check("b_hold_resp", axi.bresp, exp_resp);
            check("b_hold_awready", axi.awready, 0);
        end
        axi.bready = 1'b1;
        @(negedge clk);
        axi.bready = 1'b0;
        check("b_done_valid", axi.bvalid, 0);
        check("b_done_awready", axi.awready, 1);

        check("nwr", obs_idx.size(), n);
        for (int k = 0; k < n && k < obs_idx.size(); k++) begin
            check("wr_idx", obs_idx[k], model_idx(b, a, int'(l), k));
            check("wr_data", obs_data[k], beat_data[k]);
            check("wr_strb", obs_strb[k], beat_strb[k]);
        end
        if (n > 0) check("b_with_last_wr", b_rise_cyc, last_wr_cyc);
    endtask

    typedef struct {
        logic [1:0]  burst;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        int          last_at;
        int          bwait;
        int          strb_mode;
        logic [1:0]  exp_resp;
        int          exp_nwr;
        logic [10:0] exp_idx0;
        logic [10:0] exp_idx1;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0]  rb;
        logic [7:0]  rl;
        logic [31:0] ra;
        logic [2:0]  rs;
        int          r;
        int          rlast;

        axi.awvalid = 0; axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0;
        axi.awburst = 0; axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0;
        axi.bready = 0;

        vecs[0]  = '{2'b01, 32'h0100, 8'd3, 3'd4, 3, 0, 0, 2'b00, 4, 11'h010, 11'h011};
        vecs[1]  = '{2'b01, 32'h7FF0, 8'd1, 3'd4, 1, 0, 0, 2'b00, 2, 11'h7FF, 11'h000};
        vecs[2]  = '{2'b10, 32'h0030, 8'd3, 3'd4, 3, 0, 0, 2'b00, 4, 11'h003, 11'h000};
        vecs[3]  = '{2'b10, 32'h0030, 8'd2, 3'd4, 2, 0, 0, 2'b10, 0, 11'h000, 11'h000};
        vecs[4]  = '{2'b00, 32'h0200, 8'd2, 3'd4, 2, 0, 1, 2'b00, 3, 11'h020, 11'h020};
        vecs[5]  = '{2'b01, 32'h0040, 8'd0, 3'd2, 0, 0, 0, 2'b10, 0, 11'h000, 11'h000};
        vecs[6]  = '{2'b01, 32'h0040, 8'd0, 3'd4, 0, 0, 0, 2'b00, 1, 11'h004, 11'h000};
        vecs[7]  = '{2'b01, 32'h0080, 8'd3, 3'd4, 1, 0, 0, 2'b10, 4, 11'h008, 11'h009};
        vecs[8]  = '{2'b01, 32'h0500, 8'd0, 3'd4, 0, 5, 0, 2'b00, 1, 11'h050, 11'h000};
        vecs[9]  = '{2'b01, 32'h0108, 8'd1, 3'd4, 1, 0, 0, 2'b10, 0, 11'h000, 11'h000};
        vecs[10] = '{2'b11, 32'h0100, 8'd1, 3'd4, 1, 0, 0, 2'b10, 0, 11'h000, 11'h000};

        // Reset values, and W presented before any AW is ignored.
        axi.wvalid = 1'b1;
        axi.wdata = '1;
        axi.wstrb = '1;
        repeat (3) @(negedge clk);
        check("rst_awready", axi.awready, 1);
        check("rst_wready", axi.wready, 0);
        check("rst_bvalid", axi.bvalid, 0);
        check("rst_bid", axi.bid, 0);
        check("rst_bresp", axi.bresp, 0);
        check("rst_mem_wr_en", mem_wr_en, 0);
        check("rst_mem_wr_idx", mem_wr_idx, 0);
        check("rst_mem_wr_data", mem_wr_data, 0);
        check("rst_mem_wr_strb", mem_wr_strb, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("early_w_wready", axi.wready, 0);
            check("early_w_no_write", mem_wr_en, 0);
        end
        axi.wvalid = 1'b0;

        foreach (vecs[i]) begin
            for (int k = 0; k < 32; k++) begin
                beat_data[k] = {$urandom, $urandom, $urandom, $urandom};
                beat_strb[k] = 16'hFFFF;
            end
            if (vecs[i].strb_mode == 1) begin
                beat_strb[0] = 16'h000F;
                beat_strb[1] = 16'hFFFF;
                beat_strb[2] = 16'h0000;
            end
            run_burst(vecs[i].burst, vecs[i].addr, vecs[i].len, vecs[i].size, 4'(i + 3),
                      vecs[i].last_at, vecs[i].bwait, 1'b0);
            check("tbl_nwr", obs_idx.size(), vecs[i].exp_nwr);
            if (vecs[i].exp_nwr > 0) check("tbl_idx0", obs_idx[0], vecs[i].exp_idx0);
            if (vecs[i].exp_nwr > 1) check("tbl_idx1", obs_idx[1], vecs[i].exp_idx1);
            check("tbl_bresp", axi.bresp, vecs[i].exp_resp);
        end

        // Reset mid-burst with a write pulse pending.
        @(negedge clk);
        axi.awvalid = 1'b1; axi.awid = 4'h9; axi.awaddr = 32'h0100; axi.awlen = 8'd3;
        axi.awsize = 3'd4; axi.awburst = 2'b01;
        @(negedge clk);
        axi.awvalid = 1'b0;
        axi.wvalid = 1'b1; axi.wdata = 128'hA5; axi.wstrb = '1; axi.wlast = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("mid_pending_wr", mem_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", mem_wr_en, 0);
        check("mid_rst_awready", axi.awready, 1);
        check("mid_rst_wready", axi.wready, 0);
        check("mid_rst_idx", mem_wr_idx, 0);
        check("mid_rst_data", mem_wr_data, 0);
        axi.wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("mid_no_b", axi.bvalid, 0);
            check("mid_no_wr", mem_wr_en, 0);
        end

        // Randomized bursts against the model.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            rb = (r < 1) ? 2'b11 : (r < 4) ? 2'b10 : (r < 6) ? 2'b00 : 2'b01;
            r = $urandom_range(0, 6);
            rl = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd3 : (r == 3) ? 8'd7 :
                 (r == 4) ? 8'd15 : 8'($urandom_range(0, 31));
            ra = ($urandom & 32'hFFFF_FFF0);
            if ($urandom_range(0, 9) == 0) ra = ra | 32'h4;
            rs = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd4;
            rlast = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(rl) + 1)) : int'(rl);
            for (int k = 0; k < 32; k++) begin
                beat_data[k] = {$urandom, $urandom, $urandom, $urandom};
                beat_strb[k] = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            end
            run_burst(rb, ra, rl, rs, 4'($urandom), rlast, $urandom_range(0, 3), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
